program_loader: RTL

- Boot-time loader on the receive side of the UART load protocol.
- On `start` it transmits a sync byte through the existing `uart_tx`, then consumes a length-prefixed program stream from `uart_rx`.
- It writes each assembled 32-bit word into instruction memory, and acknowledges completion with a final byte.
- It sits between the UART cores and the instruction BRAM write port; the core holds in LOAD mode until `done`.

---
 rtl/program_loader_pkg.sv | 21 ++
 rtl/program_loader_assembler.sv | 48 ++++
 rtl/program_loader.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the UART program loader.
// The host-side bench model imports the same package.
package program_loader_pkg;

    localparam logic [7:0] LOADER_SYNC_BYTE = 8'hAA;
    localparam logic [7:0] LOADER_ACK_BYTE  = 8'hAA;

    typedef enum logic [3:0] {
        IDLE,
        SYNC_TX,
        SYNC_WAIT,
        RX_LEN,
        RX_WORD,
        WRITE,
        ACK_TX,
        ACK_WAIT,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/program_loader_assembler.sv
// Shifts bytes MSB-first into a 32-bit word and pulses word_valid on the
// cycle after the fourth byte lands in the register.
module byte_to_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        strobe,
    input  logic        clear,
    output logic [31:0] word,
    output logic [1:0]  count,
    output logic        word_valid
);

    logic [31:0] word_q, word_d;
    logic [1:0]  count_q, count_d;
    logic        valid_q, valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        word_d  = word_q;
        count_d = count_q;
        valid_d = 1'b0;
        if (clear) begin
            word_d  = '0;
            count_d = '0;
        end else if (strobe) begin
            word_d  = {word_q[23:0], byte_in};
            count_d = count_q + 2'd1;
            valid_d = (count_q == 2'd3);
        end
    end

    assign word       = word_q;
    assign count      = count_q;
    assign word_valid = valid_q;

endmodule

// File: rtl/program_loader.sv
// Receive-side boot loader: sends a sync byte, takes a length-prefixed word
// stream from the UART, writes instruction memory and acknowledges.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned IMEM_ADDR_W = 14,
    parameter logic [7:0]  SYNC_BYTE   = LOADER_SYNC_BYTE,
    parameter logic [7:0]  ACK_BYTE    = LOADER_ACK_BYTE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             rx_data,
    input  logic                   rx_ready,
    input  logic                   ferr,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [31:0]            imem_din,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [31:0]            words_loaded
);

    localparam logic [32:0] CAPACITY = 33'd1 << IMEM_ADDR_W;

    loader_state_t          state_q, state_d;
    logic [IMEM_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]            words_q, words_d;
    logic [31:0]            len_q, len_d;
    logic                   skip_q, skip_d;

    logic        start_ok;
    logic        asm_strobe;
    logic        asm_valid;
    logic [31:0] asm_word;
    logic [1:0]  asm_count_unused;

    assign start_ok   = start && (state_q inside {IDLE, DONE, ERROR});
    // A byte landing during WRITE still counts as byte 0 of the next word.
    assign asm_strobe = rx_ready && !ferr && (state_q inside {RX_LEN, RX_WORD, WRITE});

    byte_to_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (rx_data),
        .strobe     (asm_strobe),
        .clear      (start_ok),
        .word       (asm_word),
        .count      (asm_count_unused),
        .word_valid (asm_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            words_q <= '0;
            len_q   <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            len_q   <= len_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        words_d = words_q;
        len_d   = len_q;
        skip_d  = 1'b0;
        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = SYNC_TX;
                    addr_d  = '0;
                    words_d = '0;
                    len_d   = '0;
                end
            end
            SYNC_TX: begin
                if (!tx_busy) begin
                    state_d = SYNC_WAIT;
                    skip_d  = 1'b1;
                end
            end
            // skip_q masks the cycle before uart_tx reports busy
            SYNC_WAIT: begin
                if (!skip_q && !tx_busy) state_d = RX_LEN;
            end
            RX_LEN: begin
                if (rx_ready && ferr) begin
                    state_d = ERROR;
                end else if (asm_valid) begin
                    len_d = asm_word;
                    if (asm_word == 32'd0)                 state_d = ACK_TX;
                    else if ({1'b0, asm_word} > CAPACITY) state_d = ERROR;
                    else                                   state_d = RX_WORD;
                end
            end
            RX_WORD: begin
                if (rx_ready && ferr) state_d = ERROR;
                else if (asm_valid)   state_d = WRITE;
            end
            WRITE: begin
                addr_d  = addr_q + IMEM_ADDR_W'(1);
                words_d = words_q + 32'd1;
                state_d = (words_q + 32'd1 == len_q) ? ACK_TX : RX_WORD;
            end
            ACK_TX: begin
                if (!tx_busy) begin
                    state_d = ACK_WAIT;
                    skip_d  = 1'b1;
                end
            end
            ACK_WAIT: begin
                if (!skip_q && !tx_busy) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_data  = '0;
        tx_start = 1'b0;
        imem_we  = 1'b0;
        imem_din = '0;
        busy     = !(state_q inside {IDLE, DONE, ERROR});
        done     = (state_q == DONE);
        error    = (state_q == ERROR);
        unique case (state_q)
            SYNC_TX: begin
                tx_data  = SYNC_BYTE;
                tx_start = !tx_busy;
            end
            SYNC_WAIT: tx_data = SYNC_BYTE;
            ACK_TX: begin
                tx_data  = ACK_BYTE;
                tx_start = !tx_busy;
            end
            ACK_WAIT: tx_data = ACK_BYTE;
            WRITE: begin
                imem_we  = 1'b1;
                imem_din = asm_word;
            end
            default: ;
        endcase
    end

    assign imem_addr    = addr_q;
    assign words_loaded = words_q;

endmodule
